// File: rtl/fpadd_arbiter_if.sv
// rtl/fpadd_arbiter_if.sv - requester, adder and result signals of the shared fp adder arbiter
interface fpadd_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_out;
    logic        res0_valid;
    logic        res1_valid;
    logic [31:0] res_data;
    logic        busy;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_out,
        input  req0_ready, req1_ready, add_a, add_b, res0_valid, res1_valid, res_data, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_out,
        output req0_ready, req1_ready, add_a, add_b, res0_valid, res1_valid, res_data, busy
    );
endinterface

// File: rtl/fpadd_arbiter.sv
// rtl/fpadd_arbiter.sv - round-robin sharing of one pipelined fp adder between two requesters
// A tag pipeline aligned with the adder latency steers each sum back to its issuer.
module fpadd_arbiter #(
    parameter int LATENCY = 5,
    parameter int MAX_OUT = 4,
    parameter int CW      = 3
) (
    input  logic           clk,
    input  logic           rst,
    fpadd_arbiter_if.slave bus
);
    logic [CW-1:0]    r_out0;
    logic [CW-1:0]    r_out1;
    logic             r_last;
    logic [LATENCY:0] r_tag_v;
    logic [LATENCY:0] r_tag_id;
    logic [31:0]      r_add_a;
    logic [31:0]      r_add_b;
    logic [31:0]      r_res_data;
    logic             r_res0_valid;
    logic             r_res1_valid;

    logic w_elig0, w_elig1, w_grant0, w_grant1, w_grant;
    logic w_ret, w_ret0, w_ret1;

    function automatic logic [CW-1:0] next_out(input logic [CW-1:0] cur,
                                               input logic inc, input logic dec);
        case ({inc, dec})
            2'b10:   return cur + CW'(1);
            2'b01:   return cur - CW'(1);
            default: return cur;
        endcase
    endfunction

    // Gating with rst keeps both readies low while reset is asserted.
    assign w_elig0  = rst && bus.req0_valid && (r_out0 < CW'(MAX_OUT));
    assign w_elig1  = rst && bus.req1_valid && (r_out1 < CW'(MAX_OUT));
    assign w_grant0 = w_elig0 && (!w_elig1 || r_last);
    assign w_grant1 = w_elig1 && (!w_elig0 || !r_last);
    assign w_grant  = w_grant0 || w_grant1;

    // Stage 0 rides with add_a/add_b; stages 1..LATENCY follow the adder's internal stages.
    assign w_ret  = r_tag_v[LATENCY];
    assign w_ret0 = w_ret && !r_tag_id[LATENCY];
    assign w_ret1 = w_ret &&  r_tag_id[LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out0       <= '0;
            r_out1       <= '0;
            r_last       <= 1'b1;
            r_tag_v      <= '0;
            r_tag_id     <= '0;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_res_data   <= '0;
            r_res0_valid <= 1'b0;
            r_res1_valid <= 1'b0;
        end else begin
            if (w_grant) begin
                r_add_a <= w_grant1 ? bus.req1_a : bus.req0_a;
                r_add_b <= w_grant1 ? bus.req1_b : bus.req0_b;
                r_last  <= w_grant1;
            end
            r_tag_v      <= {r_tag_v[LATENCY-1:0], w_grant};
            r_tag_id     <= {r_tag_id[LATENCY-1:0], w_grant1};
            r_res0_valid <= w_ret0;
            r_res1_valid <= w_ret1;
            if (w_ret) begin
                r_res_data <= bus.add_out;
            end
            r_out0 <= next_out(r_out0, w_grant0, w_ret0);
            r_out1 <= next_out(r_out1, w_grant1, w_ret1);
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.add_a      = r_add_a;
    assign bus.add_b      = r_add_b;
    assign bus.res_data   = r_res_data;
    assign bus.res0_valid = r_res0_valid;
    assign bus.res1_valid = r_res1_valid;
    assign bus.busy       = (r_out0 != '0) || (r_out1 != '0);
endmodule

// File: tb/tb_fpadd_arbiter.sv
// tb/tb_fpadd_arbiter.sv - directed bench for fpadd_arbiter with a behavioural pipelined adder
module tb_fpadd_arbiter;
    localparam int LAT = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fpadd_arbiter_if bus();

    fpadd_arbiter #(.LATENCY(LAT), .MAX_OUT(4), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [63:0] s2d(input logic [31:0] s);
        if (s[30:0] == 31'd0) return {s[31], 63'd0};
        return {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2s(input logic [63:0] d);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        real ra, rb;
        ra = $bitstoreal(s2d(a));
        rb = $bitstoreal(s2d(b));
        return d2s($realtobits(ra + rb));
    endfunction

    logic [31:0] r_pipe [0:LAT-1];
    always @(posedge clk) begin
        r_pipe[0] <= fadd(bus.add_a, bus.add_b);
        for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
    assign bus.add_out = r_pipe[LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] t0a [4] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40400000};
    logic [31:0] t0b [4] = '{32'h40000000, 32'h40000000, 32'h3E800000, 32'hBF800000};
    logic [31:0] t1a [4] = '{32'h3F800000, 32'h40800000, 32'h41200000, 32'hC0000000};
    logic [31:0] t1b [4] = '{32'h3F800000, 32'h40800000, 32'h40C00000, 32'hC0400000};
    logic [31:0] exp_seq [8] = '{32'h40400000, 32'h40000000, 32'h40800000, 32'h41000000,
                                 32'h3F400000, 32'h41800000, 32'h40000000, 32'hC0A00000};

    int first_at, n0, n1, i0, i1, turn, nres, peak, ngrant, grants_before, gr, rs, ncoinc;
    logic prev_g, seen;
    logic [2:0] prev_o;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b1; bus.req1_a = '0; bus.req1_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_add_a", bus.add_a, 0);
        chk("rst_res_valid", {bus.res1_valid, bus.res0_valid}, 0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        rst = 1'b1;

        // single request
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 32'h3F800000; bus.req0_b = 32'h40000000;
        #1;
        chk("single_ready0", bus.req0_ready, 1);
        chk("single_ready1", bus.req1_ready, 0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        chk("single_ready0_once", bus.req0_ready, 0);
        chk("single_add_a", bus.add_a, 32'h3F800000);
        chk("single_add_b", bus.add_b, 32'h40000000);
        chk("single_busy", bus.busy, 1);
        first_at = -1; n0 = 0; n1 = 0;
        for (int i = 2; i <= 12; i++) begin
            @(negedge clk);
            if (bus.res0_valid) begin
                n0++;
                if (first_at < 0) begin
                    first_at = i;
                    chk("single_res_data", bus.res_data, 32'h40400000);
                end
            end
            if (bus.res1_valid) n1++;
        end
        chk("single_latency", first_at, 7);
        chk("single_res0_count", n0, 1);
        chk("single_res1_count", n1, 0);
        chk("single_busy_end", bus.busy, 0);

        // contention
        do_reset();
        i0 = 0; i1 = 0; turn = 0; nres = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (bus.res0_valid || bus.res1_valid) begin
                chk("cont_res_id", {bus.res1_valid, bus.res0_valid}, (nres % 2) ? 2 : 1);
                chk("cont_res_data", bus.res_data, exp_seq[nres % 8]);
                nres++;
            end
            bus.req0_valid = (i0 < 4); bus.req0_a = t0a[i0 % 4]; bus.req0_b = t0b[i0 % 4];
            bus.req1_valid = (i1 < 4); bus.req1_a = t1a[i1 % 4]; bus.req1_b = t1b[i1 % 4];
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                chk("cont_grant", {bus.req1_ready, bus.req0_ready}, turn ? 2 : 1);
                turn ^= 1;
                if (bus.req0_ready) i0++; else i1++;
            end
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("cont_grants0", i0, 4);
        chk("cont_grants1", i1, 4);
        chk("cont_results", nres, 8);

        // credit limit
        do_reset();
        peak = 0; ngrant = 0; first_at = -1; grants_before = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.res0_valid) begin
                chk("credit_data", bus.res_data, 32'h40000000);
                if (first_at < 0) begin
                    first_at = cyc;
                    grants_before = ngrant;
                end
            end
            bus.req0_valid = 1'b1; bus.req0_a = 32'h3F800000; bus.req0_b = 32'h3F800000;
            #1;
            if (int'(dut.r_out0) > peak) peak = int'(dut.r_out0);
            if (cyc >= 4 && cyc <= 6) chk("credit_stall", bus.req0_ready, 0);
            if (first_at == cyc) chk("credit_ready_at_res", bus.req0_ready, 1);
            if (bus.req0_ready) ngrant++;
        end
        bus.req0_valid = 1'b0;
        chk("credit_first_res", first_at, 7);
        chk("credit_grants_before", grants_before, 4);
        chk("credit_peak", peak, 4);
        repeat (10) @(negedge clk);
        chk("credit_drained", bus.busy, 0);

        // steady stream from req1: grant and retire coincide
        gr = 0; rs = 0; ncoinc = 0; prev_g = 1'b0; prev_o = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.res1_valid) begin
                rs++;
                chk("stream_data", bus.res_data, 32'h41800000);
                if (prev_g) begin
                    ncoinc++;
                    chk("stream_out1_const", dut.r_out1, prev_o);
                end
            end
            chk("stream_busy", bus.busy, rs != gr);
            bus.req1_valid = (cyc < 16); bus.req1_a = 32'h41200000; bus.req1_b = 32'h40C00000;
            #1;
            prev_g = bus.req1_ready;
            prev_o = dut.r_out1;
            if (bus.req1_ready) gr++;
        end
        chk("stream_all_retired", rs, gr);
        chk("stream_coincide_seen", ncoinc > 0, 1);

        // mid-flight reset
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 32'h3F800000; bus.req0_b = 32'h40000000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_add_a", bus.add_a, 0);
        chk("mrst_add_b", bus.add_b, 0);
        chk("mrst_res_data", bus.res_data, 0);
        chk("mrst_res_valid", {bus.res1_valid, bus.res0_valid}, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_ready0", bus.req0_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        n0 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.res0_valid || bus.res1_valid) n0++;
        end
        chk("mrst_no_results", n0, 0);
        chk("mrst_busy_after", bus.busy, 0);
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 32'h3F000000; bus.req0_b = 32'h3E800000;
        bus.req1_valid = 1'b1; bus.req1_a = 32'h40800000; bus.req1_b = 32'h40800000;
        #1;
        chk("mrst_ptr_ready0", bus.req0_ready, 1);
        chk("mrst_ptr_ready1", bus.req1_ready, 0);
        first_at = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            if (bus.res0_valid && first_at < 0) begin
                first_at = i;
                chk("mrst_res_data_after", bus.res_data, 32'h3F400000);
            end
        end
        chk("mrst_latency_after", first_at, 7);

        // bubble hold
        repeat (4) @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_a = 32'h41200000; bus.req1_b = 32'h40C00000;
        #1;
        chk("bubble_ready1", bus.req1_ready, 1);
        n0 = 0; seen = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            bus.req1_valid = 1'b0; bus.req1_a = 32'hDEADBEEF; bus.req1_b = 32'hDEADBEEF;
            chk("bubble_add_a", bus.add_a, 32'h41200000);
            chk("bubble_add_b", bus.add_b, 32'h40C00000);
            if (seen) chk("bubble_res_stable", bus.res_data, 32'h41800000);
            if (bus.res0_valid || bus.res1_valid) begin
                n0++;
                seen = 1'b1;
                chk("bubble_res_id", {bus.res1_valid, bus.res0_valid}, 2);
            end
        end
        chk("bubble_pulses", n0, 1);
        chk("bubble_res_data", bus.res_data, 32'h41800000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpadd_arbiter.md
Name: fpadd_arbiter

Overview:
- Shares one fpadd_pipelined instance between two requesters: requester 0 and requester 1.
- Round-robin arbitration issues at most one operand pair per cycle into the adder.
- A tag pipeline matched to the adder latency routes each sum back to the requester that issued it.
- Sits between requester logic, such as test-vector sequencers or a CPU-side register block, and the adder's reg_A/reg_B/out ports.

Parameters:
- LATENCY, 5: cycles from operands on add_a/add_b to the matching sum on add_out. Must be ≥1.
- MAX_OUT, 4: maximum in-flight operations per requester. Must be ≥1.
- CW, 3: width of the outstanding counters. Must satisfy 2^CW > MAX_OUT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a  in  32  requester 0 operand A (IEEE-754 single)
- req0_b  in  32  requester 0 operand B
- req0_ready  out  1  requester 0 pair accepted this cycle (combinational)
- req1_valid  in  1  requester 1 has an operand pair
- req1_a  in  32  requester 1 operand A
- req1_b  in  32  requester 1 operand B
- req1_ready  out  1  requester 1 pair accepted this cycle (combinational)
- add_a  out  32  registered operand to adder reg_A
- add_b  out  32  registered operand to adder reg_B
- add_out  in  32  adder result
- res0_valid  out  1  one-cycle pulse; res_data belongs to requester 0
- res1_valid  out  1  one-cycle pulse; res_data belongs to requester 1
- res_data  out  32  registered sum
- busy  out  1  any operation in flight

Behaviour:
- Reset: one clock; asynchronous active-low reset.
  - rst=0 immediately clears add_a, add_b, res_data, res0_valid, res1_valid, both outstanding counters and all tag stages.
  - rst=0 sets the round-robin pointer so requester 0 has priority first.
  - req*_ready and busy are therefore 0 during reset.
- Eligibility: reqN is eligible when reqN_valid=1 and outN<MAX_OUT.
- Grant:
  - Only one eligible requester: grant it.
  - Both eligible: grant the one not granted most recently. Pointer updates only on a grant.
  - reqN_ready = grantN. The transfer occurs at the edge where valid and ready are both 1.
  - No requester may be ready while rst=0.
- Issue, at grant edge E:
  - add_a/add_b load the granted a/b.
  - Tag stage 0 loads {valid=1, id=N}.
- No grant:
  - add_a/add_b hold their previous values.
  - Tag stage 0 loads valid=0, which is a bubble.
- Tag pipeline: LATENCY stages, shifting every cycle with no stall, because the adder has no enable.
- Retire: at edge E+LATENCY+1 the final tag stage is valid, and:
  - res_data <= add_out.
  - resN_valid <= 1 for the tagged id; the other resN_valid <= 0.
  - resN_valid is 0 in any cycle without a retire.
- Grant-to-result latency is exactly LATENCY+1 cycles.
- Throughput: one issue per cycle in steady state.
- Result ordering: results return in issue order, independent of requester.
- Outstanding counters:
  - outN increments on grantN and decrements on retire of id N.
  - Grant and retire for the same N in the same cycle leave outN unchanged.
  - outN never exceeds MAX_OUT and never underflows.
- Result handshake: there is no backpressure on results. Requesters must accept every resN_valid pulse.
- busy = (out0≠0) or (out1≠0).
- Reset mid-operation: all in-flight results are discarded, with no resN_valid after reset. Any late add_out values are ignored because all tags are invalid.
- Counters are CW-bit unsigned and are not allowed to wrap.

Test Plan:
- Single request: reset, then req0 issues a=3F800000, b=40000000 once (LATENCY=5).
  - Required: req0_ready=1 for 1 cycle.
  - Required: add_a/add_b show the pair next cycle.
  - Required: with the bench adder model, res0_valid pulses exactly 6 cycles after the grant edge, res_data=40400000, and res1_valid stays 0.
- Contention: req0 and req1 held valid continuously.
  - Required: grants alternate 0,1,0,1…, starting with 0 after reset.
  - Required: 8 results return in order 0,1,0,1…, each with the matching sum.
- Credit limit: req0 valid continuously with a held-off adder result path (LATENCY=5, MAX_OUT=4).
  - Required: exactly 4 grants, then req0_ready=0 until the first res0_valid.
  - Required: out0 peaks at 4, then steady state keeps out0 ≤ 4.
- Simultaneous grant and retire: a steady stream from req1.
  - Required: out1 is constant on cycles with both a grant and a retire.
  - Required: busy=1 throughout; busy=0 one cycle after the last retire.
- Mid-flight reset: issue 3 ops, assert rst=0 for 1 cycle before the first retire.
  - Required: all outputs are 0 immediately, no resN_valid afterward, busy=0.
  - Required: the next request after reset is granted to req0 and its result is correct.
- Bubble hold: grant one op, then 10 idle cycles.
  - Required: add_a/add_b hold their values, only one resN_valid pulse occurs, and res_data stays stable after it.
